// File: rtl/hazard_scoreboard_unit.sv
// Hazard, forwarding and multi-cycle scoreboard unit for the 5-stage RV core.
// Purpose: combinational EX/branch forwarding selects and stall/flush control,
// plus a registered scoreboard tracking the destination of one outstanding
// multi-cycle (div/mul) op, a BUSY/IDLE tracker and a sticky watchdog flag.
// Ports:
//   i_clk, i_rst_n                      clock, async active-low reset
//   i_rs1_d/i_rs2_d/i_rd_d, ...         D-stage indices and controls
//   i_rs1_e/i_rs2_e/i_rd_e, ...         E-stage indices and controls
//   i_rd_m/i_rd_w, ...                  M/W destination indices and controls
//   i_mc_done                           multi-cycle result in W this cycle
//   o_stall_f/o_stall_d                 hold PC and IF/ID
//   o_flush_d/o_flush_e                 bubble IF/ID and ID/EX
//   o_forward_ae/be                     ALU operand selects
//   o_branch_forward_ae/be              D-stage comparator selects
//   o_mc_busy, o_mc_timeout             multi-cycle state, sticky watchdog
//   o_sb_pending                        scoreboard vector (debug)
module hazard_scoreboard_unit #(
  parameter int unsigned NREG       = 32,
  parameter int unsigned REG_W      = 5,
  parameter int unsigned MC_TIMEOUT = 64,
  parameter bit          BR_FWD_EX  = 1'b1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [REG_W-1:0] i_rs1_d,
  input  logic [REG_W-1:0] i_rs2_d,
  input  logic [REG_W-1:0] i_rd_d,
  input  logic             i_regwrite_d,
  input  logic             i_is_branch_d,
  input  logic             i_mc_op_d,
  input  logic             i_pcsrc_d,
  input  logic [REG_W-1:0] i_rs1_e,
  input  logic [REG_W-1:0] i_rs2_e,
  input  logic [REG_W-1:0] i_rd_e,
  input  logic             i_regwrite_e,
  input  logic             i_memtoreg_e,
  input  logic             i_mc_start_e,
  input  logic [REG_W-1:0] i_rd_m,
  input  logic [REG_W-1:0] i_rd_w,
  input  logic             i_regwrite_m,
  input  logic             i_memtoreg_m,
  input  logic             i_regwrite_w,
  input  logic             i_mc_done,
  output logic             o_stall_f,
  output logic             o_stall_d,
  output logic             o_flush_d,
  output logic             o_flush_e,
  output logic [1:0]       o_forward_ae,
  output logic [1:0]       o_forward_be,
  output logic [1:0]       o_branch_forward_ae,
  output logic [1:0]       o_branch_forward_be,
  output logic             o_mc_busy,
  output logic             o_mc_timeout,
  output logic [NREG-1:0]  o_sb_pending
);

  localparam int unsigned WD_W = 10;  // covers MC_TIMEOUT up to 1023

  typedef enum logic {StIdle, StBusy} state_e;

  state_e           r_state;
  logic [NREG-1:0]  r_sb_pending;
  logic [REG_W-1:0] r_mc_rd;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_mc_timeout;

  logic w_stall;

  // x0 never produces a hazard or a forward.
  function automatic logic f_match(input logic [REG_W-1:0] a, input logic [REG_W-1:0] b);
    return (a != '0) && (a == b);
  endfunction

  function automatic logic [1:0] f_fwd_e(input logic [REG_W-1:0] rs);
    if (i_regwrite_m && f_match(i_rd_m, rs))      return 2'b10;
    else if (i_regwrite_w && f_match(i_rd_w, rs)) return 2'b01;
    else                                          return 2'b00;
  endfunction

  function automatic logic [1:0] f_fwd_br(input logic [REG_W-1:0] rs);
    if (BR_FWD_EX && i_regwrite_e && !i_memtoreg_e && f_match(i_rd_e, rs)) return 2'b01;
    else if (i_regwrite_m && !i_memtoreg_m && f_match(i_rd_m, rs))         return 2'b10;
    else if (i_regwrite_w && f_match(i_rd_w, rs))                          return 2'b11;
    else                                                                   return 2'b00;
  endfunction

  always_comb begin
    o_forward_ae        = f_fwd_e(i_rs1_e);
    o_forward_be        = f_fwd_e(i_rs2_e);
    o_branch_forward_ae = f_fwd_br(i_rs1_d);
    o_branch_forward_be = f_fwd_br(i_rs2_d);
  end

  always_comb begin
    w_stall = 1'b0;
    // Load-use
    if (i_memtoreg_e && (f_match(i_rd_e, i_rs1_d) || f_match(i_rd_e, i_rs2_d))) w_stall = 1'b1;
    // Branch compares in D but the load value only exists after M
    if (i_is_branch_d && i_memtoreg_m &&
        (f_match(i_rd_m, i_rs1_d) || f_match(i_rd_m, i_rs2_d))) w_stall = 1'b1;
    // Without E->D forwarding, a branch must wait for the E result
    if (!BR_FWD_EX && i_is_branch_d && i_regwrite_e &&
        (f_match(i_rd_e, i_rs1_d) || f_match(i_rd_e, i_rs2_d))) w_stall = 1'b1;
    // Scoreboard is read registered: dependents still stall in the mc_done cycle
    if (r_sb_pending[i_rs1_d] || r_sb_pending[i_rs2_d]) w_stall = 1'b1;
    if (i_regwrite_d && r_sb_pending[i_rd_d]) w_stall = 1'b1;
    // Only one multi-cycle op may be outstanding
    if (i_mc_op_d && ((r_state == StBusy) || i_mc_start_e)) w_stall = 1'b1;
  end

  always_comb begin
    o_stall_f    = w_stall;
    o_stall_d    = w_stall;
    o_flush_e    = w_stall;
    // A stalled branch has not resolved yet, so it must not redirect.
    o_flush_d    = i_pcsrc_d && !w_stall;
    o_mc_busy    = (r_state == StBusy);
    o_mc_timeout = r_mc_timeout;
    o_sb_pending = r_sb_pending;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= StIdle;
      r_sb_pending <= '0;
      r_mc_rd      <= '0;
      r_wd_cnt     <= '0;
      r_mc_timeout <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          // mc_done while idle is ignored
          if (i_mc_start_e) begin
            r_state  <= StBusy;
            r_mc_rd  <= i_rd_e;
            r_wd_cnt <= '0;
            if (i_regwrite_e && (i_rd_e != '0)) r_sb_pending[i_rd_e] <= 1'b1;
          end
        end
        StBusy: begin
          // a second mc_start_e while busy is ignored
          if (i_mc_done) begin
            r_state               <= StIdle;
            r_sb_pending[r_mc_rd] <= 1'b0;
          end else if (r_wd_cnt == WD_W'(MC_TIMEOUT - 1)) begin
            r_state               <= StIdle;
            r_sb_pending[r_mc_rd] <= 1'b0;
            r_mc_timeout          <= 1'b1;
          end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit. Two instances share all inputs:
// index 0 with branch forwarding from E and an 8-cycle watchdog, index 1 with
// branch-on-E stalling and a 16-cycle watchdog. Every cycle both are compared
// against a behavioural model; directed scenarios add fixed expectations.
module tb_hazard_scoreboard_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic       regwrite_d, is_branch_d, mc_op_d, pcsrc_d;
  logic       regwrite_e, memtoreg_e, mc_start_e;
  logic       regwrite_m, memtoreg_m, regwrite_w, mc_done;

  logic        stall_f[2], stall_d[2], flush_d[2], flush_e[2], busy[2], tmo[2];
  logic [1:0]  fwd_ae[2], fwd_be[2], bfwd_ae[2], bfwd_be[2];
  logic [31:0] pend[2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_scoreboard_unit #(
    .NREG(32), .REG_W(5), .MC_TIMEOUT(8), .BR_FWD_EX(1'b1)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d), .i_regwrite_d(regwrite_d),
    .i_is_branch_d(is_branch_d), .i_mc_op_d(mc_op_d), .i_pcsrc_d(pcsrc_d),
    .i_rs1_e(rs1_e), .i_rs2_e(rs2_e), .i_rd_e(rd_e), .i_regwrite_e(regwrite_e),
    .i_memtoreg_e(memtoreg_e), .i_mc_start_e(mc_start_e),
    .i_rd_m(rd_m), .i_rd_w(rd_w), .i_regwrite_m(regwrite_m), .i_memtoreg_m(memtoreg_m),
    .i_regwrite_w(regwrite_w), .i_mc_done(mc_done),
    .o_stall_f(stall_f[0]), .o_stall_d(stall_d[0]), .o_flush_d(flush_d[0]),
    .o_flush_e(flush_e[0]), .o_forward_ae(fwd_ae[0]), .o_forward_be(fwd_be[0]),
    .o_branch_forward_ae(bfwd_ae[0]), .o_branch_forward_be(bfwd_be[0]),
    .o_mc_busy(busy[0]), .o_mc_timeout(tmo[0]), .o_sb_pending(pend[0])
  );

  hazard_scoreboard_unit #(
    .NREG(32), .REG_W(5), .MC_TIMEOUT(16), .BR_FWD_EX(1'b0)
  ) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d), .i_regwrite_d(regwrite_d),
    .i_is_branch_d(is_branch_d), .i_mc_op_d(mc_op_d), .i_pcsrc_d(pcsrc_d),
    .i_rs1_e(rs1_e), .i_rs2_e(rs2_e), .i_rd_e(rd_e), .i_regwrite_e(regwrite_e),
    .i_memtoreg_e(memtoreg_e), .i_mc_start_e(mc_start_e),
    .i_rd_m(rd_m), .i_rd_w(rd_w), .i_regwrite_m(regwrite_m), .i_memtoreg_m(memtoreg_m),
    .i_regwrite_w(regwrite_w), .i_mc_done(mc_done),
    .o_stall_f(stall_f[1]), .o_stall_d(stall_d[1]), .o_flush_d(flush_d[1]),
    .o_flush_e(flush_e[1]), .o_forward_ae(fwd_ae[1]), .o_forward_be(fwd_be[1]),
    .o_branch_forward_ae(bfwd_ae[1]), .o_branch_forward_be(bfwd_be[1]),
    .o_mc_busy(busy[1]), .o_mc_timeout(tmo[1]), .o_sb_pending(pend[1])
  );

  // ---------------- reference model ----------------
  int cfg_brfwd[2] = '{1, 0};
  int cfg_tmo[2]   = '{8, 16};
  bit m_busy[2];
  bit m_wr[2];
  bit m_to[2];
  int m_rd[2];
  int m_age[2];

  // At most one op is outstanding, so the pending set is {m_rd} or empty.
  function automatic bit m_pend(int k, int r);
    return m_busy[k] && m_wr[k] && (m_rd[k] != 0) && (m_rd[k] == r);
  endfunction

  function automatic logic [31:0] m_pend_vec(int k);
    logic [31:0] v = '0;
    for (int r = 0; r < 32; r++) v[r] = m_pend(k, r);
    return v;
  endfunction

  function automatic bit hit(int a, int b);
    return (a != 0) && (a == b);
  endfunction

  function automatic int m_fwd(int rs);
    if (regwrite_m && hit(rd_m, rs)) return 2;
    if (regwrite_w && hit(rd_w, rs)) return 1;
    return 0;
  endfunction

  function automatic int m_bfwd(int k, int rs);
    if (cfg_brfwd[k] == 1 && regwrite_e && !memtoreg_e && hit(rd_e, rs)) return 1;
    if (regwrite_m && !memtoreg_m && hit(rd_m, rs)) return 2;
    if (regwrite_w && hit(rd_w, rs)) return 3;
    return 0;
  endfunction

  function automatic bit m_stall(int k);
    bit dep_e = hit(rd_e, rs1_d) || hit(rd_e, rs2_d);
    bit dep_m = hit(rd_m, rs1_d) || hit(rd_m, rs2_d);
    return (memtoreg_e && dep_e) ||
           (is_branch_d && memtoreg_m && dep_m) ||
           (cfg_brfwd[k] == 0 && is_branch_d && regwrite_e && dep_e) ||
           m_pend(k, rs1_d) || m_pend(k, rs2_d) ||
           (regwrite_d && m_pend(k, rd_d)) ||
           (mc_op_d && (m_busy[k] || mc_start_e));
  endfunction

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_busy[k] = 0; m_wr[k] = 0; m_to[k] = 0; m_rd[k] = 0; m_age[k] = 0;
    end
  endtask

  task automatic m_clock();
    if (!rst_n) begin
      m_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      if (!m_busy[k]) begin
        if (mc_start_e) begin
          m_busy[k] = 1; m_rd[k] = rd_e; m_wr[k] = regwrite_e; m_age[k] = 0;
        end
      end else begin
        m_age[k]++;
        if (mc_done) m_busy[k] = 0;
        else if (m_age[k] == cfg_tmo[k]) begin
          m_busy[k] = 0; m_to[k] = 1;
        end
      end
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      bit s = m_stall(k);
      chk($sformatf("d%0d stall_f", k), 32'(stall_f[k]), 32'(s));
      chk($sformatf("d%0d stall_d", k), 32'(stall_d[k]), 32'(s));
      chk($sformatf("d%0d flush_e", k), 32'(flush_e[k]), 32'(s));
      chk($sformatf("d%0d flush_d", k), 32'(flush_d[k]), 32'(pcsrc_d && !s));
      chk($sformatf("d%0d fwd_ae", k), 32'(fwd_ae[k]), 32'(m_fwd(rs1_e)));
      chk($sformatf("d%0d fwd_be", k), 32'(fwd_be[k]), 32'(m_fwd(rs2_e)));
      chk($sformatf("d%0d bfwd_ae", k), 32'(bfwd_ae[k]), 32'(m_bfwd(k, rs1_d)));
      chk($sformatf("d%0d bfwd_be", k), 32'(bfwd_be[k]), 32'(m_bfwd(k, rs2_d)));
      chk($sformatf("d%0d busy", k), 32'(busy[k]), 32'(m_busy[k]));
      chk($sformatf("d%0d timeout", k), 32'(tmo[k]), 32'(m_to[k]));
      chk($sformatf("d%0d pending", k), pend[k], m_pend_vec(k));
    end
  endtask

  task automatic sample();
    @(negedge clk);
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic clear_inputs();
    {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_e, rd_m, rd_w} = '0;
    {regwrite_d, is_branch_d, mc_op_d, pcsrc_d} = '0;
    {regwrite_e, memtoreg_e, mc_start_e} = '0;
    {regwrite_m, memtoreg_m, regwrite_w, mc_done} = '0;
  endtask

  // Return both instances to idle.
  task automatic settle();
    clear_inputs();
    mc_done = 1'b1;
    sample(); tick();
    mc_done = 1'b0;
  endtask

  task automatic start_mc(input int rd);
    clear_inputs();
    mc_start_e = 1'b1; rd_e = 5'(rd); regwrite_e = 1'b1;
    sample(); tick();
    clear_inputs();
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    m_reset();
    #3;
    for (int k = 0; k < 2; k++) begin
      chk("reset stall", 32'(stall_f[k]), 0);
      chk("reset busy", 32'(busy[k]), 0);
      chk("reset pending", pend[k], 0);
      chk("reset fwd", 32'({fwd_ae[k], bfwd_ae[k]}), 0);
    end
    #4 rst_n = 1'b1;
    tick();

    // Load-use then W forwarding of the loaded value
    memtoreg_e = 1; regwrite_e = 1; rd_e = 5; rs1_d = 5; rs2_d = 1;
    sample();
    chk("loaduse stall", 32'(stall_f[0]), 1);
    chk("loaduse flush_e", 32'(flush_e[1]), 1);
    tick();
    clear_inputs();
    rs1_e = 5; rs2_e = 1; rd_w = 5; regwrite_w = 1;
    sample();
    chk("loaduse fwd_ae", 32'(fwd_ae[0]), 1);
    chk("loaduse nostall", 32'(stall_d[0]), 0);
    tick();

    // EX forwarding priority
    clear_inputs();
    rd_m = 7; rd_w = 7; regwrite_m = 1; regwrite_w = 1; rs2_e = 7;
    sample(); chk("fwd_be M", 32'(fwd_be[0]), 2); tick();
    regwrite_m = 0;
    sample(); chk("fwd_be W", 32'(fwd_be[0]), 1); tick();
    rs2_e = 0;
    sample(); chk("fwd_be x0", 32'(fwd_be[0]), 0); tick();

    // Branch forwarding modes
    clear_inputs();
    is_branch_d = 1; rs1_d = 4; regwrite_e = 1; rd_e = 4;
    sample();
    chk("brfwd1 sel", 32'(bfwd_ae[0]), 1);
    chk("brfwd1 stall", 32'(stall_f[0]), 0);
    chk("brfwd0 stall", 32'(stall_f[1]), 1);
    tick();

    // Watchdog on instance 0 (8 cycles)
    settle();
    start_mc(3);
    for (int c = 1; c <= 9; c++) begin
      sample();
      if (c == 8) chk("wd busy@8", 32'({busy[0], pend[0][3]}), 32'h3);
      if (c == 9) chk("wd abort", 32'({busy[0], tmo[0], pend[0][3]}), 32'h2);
      tick();
    end

    // Divide scoreboard on instance 1: dependent held until one cycle after mc_done
    settle();
    start_mc(9);
    rs1_d = 9;
    for (int c = 1; c <= 14; c++) begin
      mc_done = (c == 13);
      sample();
      chk($sformatf("div stall c%0d", c), 32'(stall_f[1]), 32'(c <= 13));
      if (c == 13) chk("div pend@done", 32'(pend[1][9]), 1);
      if (c == 14) chk("div pend clr", 32'(pend[1][9]), 0);
      tick();
    end

    // Structural, WAW, and flush suppression during stall
    settle();
    start_mc(9);
    mc_op_d = 1;
    sample(); chk("struct stall", 32'(stall_f[1]), 1); tick();
    mc_op_d = 0; regwrite_d = 1; rd_d = 9; pcsrc_d = 1;
    sample();
    chk("waw stall", 32'(stall_d[1]), 1);
    chk("flush_d in stall", 32'(flush_d[1]), 0);
    tick();
    regwrite_d = 0; mc_done = 1;
    sample(); chk("flush_d taken", 32'(flush_d[1]), 1); tick();

    // Asynchronous reset while busy
    settle();
    start_mc(6);
    sample(); tick();
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("arst busy", 32'({busy[0], busy[1]}), 0);
    chk("arst pend", pend[0] | pend[1], 0);
    chk("arst tmo", 32'({tmo[0], tmo[1]}), 0);
    sample(); tick();
    #2 rst_n = 1'b1;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rs1_d = 5'($urandom_range(0, 7)); rs2_d = 5'($urandom_range(0, 7));
      rd_d  = 5'($urandom_range(0, 7)); rs1_e = 5'($urandom_range(0, 7));
      rs2_e = 5'($urandom_range(0, 7)); rd_e  = 5'($urandom_range(0, 7));
      rd_m  = 5'($urandom_range(0, 7)); rd_w  = 5'($urandom_range(0, 7));
      regwrite_d = 1'($urandom); is_branch_d = 1'($urandom);
      mc_op_d = ($urandom_range(0, 3) == 0); pcsrc_d = 1'($urandom);
      regwrite_e = 1'($urandom); memtoreg_e = ($urandom_range(0, 3) == 0);
      mc_start_e = ($urandom_range(0, 5) == 0);
      regwrite_m = 1'($urandom); memtoreg_m = ($urandom_range(0, 3) == 0);
      regwrite_w = 1'($urandom); mc_done = ($urandom_range(0, 9) == 0);
      sample(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
Next-generation hazard and forwarding unit for the 5-stage pipelined RV core. It keeps the combinational forwarding and stall logic. It adds a registered scoreboard that tracks destination registers of an outstanding multi-cycle (div/mul) operation, a BUSY/IDLE tracker for that unit, a watchdog timeout, and parametrised register count and branch-forwarding mode. It sits beside the D/E pipeline registers and drives PC/IF-ID stall, ID-EX flush and both operand-mux selects.

Parameters:
NREG, 32, number of architectural registers; x0 is hard-wired zero and never tracked.
REG_W, 5, register index width; must equal clog2(NREG).
MC_TIMEOUT, 64, maximum cycles in BUSY before forced abort; legal range 2..1023.
BR_FWD_EX, 1, 1 = branch operands may be forwarded from E; 0 = stall instead.

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
rs1_d, rs2_d, rd_d  in  REG_W each  source and destination indices in D
regwrite_d  in  1  instruction in D writes rd_d
is_branch_d  in  1  instruction in D compares operands in D
mc_op_d  in  1  instruction in D is a multi-cycle op
pcsrc_d  in  1  branch/jump taken, resolved in D
rs1_e, rs2_e, rd_e  in  REG_W each  indices in E
regwrite_e, memtoreg_e  in  1 each  E-stage controls
mc_start_e  in  1  multi-cycle op launching from E this cycle
rd_m, rd_w  in  REG_W each  M and W destination indices
regwrite_m, memtoreg_m, regwrite_w  in  1 each  M and W controls
mc_done  in  1  one-cycle pulse: multi-cycle result is in W this cycle
stall_f, stall_d  out  1 each  hold PC and IF/ID
flush_d, flush_e  out  1 each  bubble IF/ID and ID/EX
forward_ae, forward_be  out  2 each  ALU operand select
branch_forward_ae, branch_forward_be  out  2 each  D-stage comparator select
mc_busy  out  1  multi-cycle unit occupied (registered)
mc_timeout  out  1  sticky watchdog flag
sb_pending  out  NREG  scoreboard vector (debug)

Behaviour:
- Reset (async, rst_n=0):
  - Registers: state=IDLE, sb_pending=0, mc_rd=0, wd_cnt=0, mc_timeout=0.
  - Combinational outputs then follow their equations, giving 0 when all inputs are 0.
- Match rule:
  - An index matches only when it is nonzero.
  - sb_pending[0] is never set.
- Forwarding to EX (per operand, A shown):
  - 10 if regwrite_m and rd_m==rs1_e.
  - Else 01 if regwrite_w and rd_w==rs1_e.
  - Else 00.
- Branch forwarding in D (per operand):
  - 01 if BR_FWD_EX and regwrite_e and not memtoreg_e and rd_e matches.
  - Else 10 if regwrite_m and not memtoreg_m and rd_m matches.
  - Else 11 if regwrite_w and rd_w matches.
  - Else 00.
- stall is the OR of these terms:
  - (a) Load-use: memtoreg_e and rd_e matches rs1_d or rs2_d.
  - (b) Branch on load in M: is_branch_d and memtoreg_m and rd_m matches.
  - (c) Branch on E result: BR_FWD_EX=0 and is_branch_d and regwrite_e and rd_e matches.
  - (d) RAW on scoreboard: sb_pending[rs1_d] or sb_pending[rs2_d].
  - (e) WAW: regwrite_d and sb_pending[rd_d].
  - (f) Structural: mc_op_d and (state==BUSY or mc_start_e).
- When stall=1: stall_f=stall_d=flush_e=1.
- flush_d = pcsrc_d and not stall. A stalled branch has not resolved.
- FSM, IDLE→BUSY:
  - Taken on mc_start_e.
  - Latch mc_rd=rd_e; if regwrite_e, set sb_pending[rd_e]; wd_cnt=0.
- FSM, BUSY→IDLE:
  - Taken on mc_done: clear sb_pending[mc_rd].
  - Also taken when wd_cnt==MC_TIMEOUT-1 without mc_done: clear sb_pending[mc_rd], set mc_timeout.
  - Otherwise wd_cnt increments each BUSY cycle.
- The scoreboard is read registered, so a dependent instruction stalls during the mc_done cycle. It releases the next cycle and reads the register file; the penalty is exactly 1 cycle.
- mc_done in IDLE is ignored. mc_start_e in BUSY is a protocol violation, cannot occur while (f) holds, and is ignored.
- mc_busy = (state==BUSY).
- mc_timeout clears only on reset.

Test Plan:
- Load-use: lw x5 in E (memtoreg_e=1, rd_e=5), add x6,x5,x1 in D → stall_f=stall_d=flush_e=1 one cycle. Next cycle forward_ae=01.
- EX forwarding priority: rd_m=rd_w=7, regwrite_m=regwrite_w=1, rs2_e=7 → forward_be=10. With regwrite_m=0 → 01. With rs2_e=0 → 00.
- Div scoreboard: mc_start_e with rd_e=9, then mc_done 12 cycles later. Instruction with rs1_d=9 held → stall high for cycles 1..13, low on cycle 14. sb_pending[9] drops at the edge after mc_done.
- Structural and WAW: mc_op_d while BUSY → stall. regwrite_d with rd_d=9 while pending → stall. pcsrc_d=1 during stall → flush_d=0.
- Branch forwarding modes: is_branch_d, rs1_d=4, regwrite_e, rd_e=4 → BR_FWD_EX=1 gives branch_forward_ae=01, no stall. BR_FWD_EX=0 gives stall=1.
- Watchdog and reset: MC_TIMEOUT=8, start with no mc_done → mc_timeout=1 and mc_busy=0 after 8 BUSY cycles, sb_pending cleared. rst_n low mid-BUSY → all registered state 0 immediately, asynchronously.
